control: RTL and testbench
==========================

CONTROL -- requirements
Module: control

Interface
REQ-001 No parameters.
REQ-002 clk  in  1  system clock; no output depends on it (block is combinational apart from reset gating).
REQ-003 rst_n  in  1  asynchronous, active-low reset.
REQ-004 inst  in  8  current instruction byte; i7..i0 below denote inst[7]..inst[0].
REQ-005 cycle  in  1  execution phase (0 = first cycle, 1 = second cycle).
REQ-006 ncycle  in  1  complement of cycle; driver SHALL keep ncycle = ~cycle; outputs are defined from cycle.
REQ-007 carry  in  1  ALU carry flag.
REQ-008 M, S, J, LJ, MW, MC, RD, WR, Y, WA, WC  out  1 each  active-high control strobes.
REQ-009 nCLI, nLJR, nISP  out  1 each  active-low control strobes.
REQ-010 RS  out  2  register select; ALU  out  4  ALU opcode; nSIG  out  8  active-low one-hot signal lines.

Function (rst_n=1; purely combinational, zero latency, no state)
REQ-011 Define Z = ~i7&~i6&~i5&~i4 and P = (i6&~i7) | (cycle&i6&~i5).
REQ-012 M SHALL equal i7&~i6&cycle.
REQ-013 S SHALL equal i4.
REQ-014 J SHALL equal i7&i6&i5&cycle&~(carry&i4).
REQ-015 LJ SHALL equal ~i7&~i6&~i5&i4&~i3.
REQ-016 nCLI SHALL equal ~(LJ&i1).
REQ-017 nLJR SHALL equal ~(LJ&i2).
REQ-018 MW SHALL equal M&i5.
REQ-019 MC SHALL equal i7&~cycle.
REQ-020 RD SHALL equal Z&i2.
REQ-021 WR SHALL equal Z&i3.
REQ-022 Y SHALL equal i5.
REQ-023 RS SHALL equal {i1|i6, i0}.
REQ-024 WA SHALL equal (M&~i5) | (P&~(i4&~i3&~i2)).
REQ-025 nISP SHALL equal ~(~i7&~i6&i5).
REQ-026 WC SHALL equal (P | ~nISP) & i4.
REQ-027 ALU SHALL equal inst[3:0] when i6=1, else {0, ~i7&i5, 0, 0}.
REQ-028 nSIG SHALL equal ~(1 << inst[2:0]) when ~i7&~i6&~i5&i4&i3 = 1, else 8'hFF; never more than one bit low.
REQ-029 Every output SHALL settle within one combinational delay of any input change; carry affects only J.

Reset
REQ-030 While rst_n=0, outputs SHALL be forced asynchronously to their inactive values: M=S=J=LJ=MW=MC=RD=WR=Y=WA=WC=0, nCLI=nLJR=nISP=1, RS=2'b00, ALU=4'h0, nSIG=8'hFF.
REQ-031 On rst_n rising, outputs SHALL immediately follow REQ-011..REQ-028 with no clock edge required.

Verification
REQ-032 inst=8'h80, cycle=1, carry=0 -> M=1, WA=1, MW=0, MC=0, ALU=0, RS=00, nISP=1, nSIG=FF; same with cycle=0 -> M=0, MC=1, WA=0.
REQ-033 inst=8'hF0, cycle=1: carry=1 -> J=0; carry=0 -> J=1; both S=1, WA=0, WC=0, ALU=0.
REQ-034 inst=8'h16 -> LJ=1, nCLI=0, nLJR=0, S=1, RS=10, nSIG=FF; inst=8'h1E -> LJ=0, nSIG=8'hBF.
REQ-035 inst=8'h0C -> RD=1, WR=1, RS=00; inst=8'h24 -> nISP=0, Y=1, ALU=4, RD=0, WC=0.
REQ-036 inst=8'h45, cycle=0 -> ALU=5, RS=11, WA=1, WC=0, M=0.
REQ-037 Exhaustive sweep of all 1024 {inst, cycle, carry} combinations checked against REQ-011..REQ-028, then rst_n=0 mid-sweep -> all outputs at REQ-030 values without a clock edge.

Source files
------------

// File: rtl/control.sv
// Instruction decoder producing the datapath control strobes for one instruction byte.
// Purely combinational; rst_n asynchronously forces every strobe to its inactive level.
module control (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [7:0] inst,
  input  logic       cycle,
  input  logic       ncycle,
  input  logic       carry,
  output logic       M,
  output logic       S,
  output logic       J,
  output logic       LJ,
  output logic       MW,
  output logic       MC,
  output logic       RD,
  output logic       WR,
  output logic       Y,
  output logic       WA,
  output logic       WC,
  output logic       nCLI,
  output logic       nLJR,
  output logic       nISP,
  output logic [1:0] RS,
  output logic [3:0] ALU,
  output logic [7:0] nSIG
);

  // clk has no function here and ncycle is redundant with cycle; both are kept for pinout compatibility.
  logic unusedInputs;
  assign unusedInputs = &{1'b0, clk, ncycle};

  logic i7, i6, i5, i4, i3, i2, i1;
  assign {i7, i6, i5, i4, i3, i2, i1} = inst[7:1];

  logic zeroHigh;   // upper nibble is zero: register read/write group
  logic wrPath;     // P term: writes through the accumulator path
  logic memAccess;  // M before reset gating
  logic longJump;   // LJ before reset gating
  logic stackOp;    // ~nISP before reset gating
  logic sigEnable;  // signal-line group

  assign zeroHigh  = ~i7 & ~i6 & ~i5 & ~i4;
  assign wrPath    = (i6 & ~i7) | (cycle & i6 & ~i5);
  assign memAccess = i7 & ~i6 & cycle;
  assign longJump  = ~i7 & ~i6 & ~i5 & i4 & ~i3;
  assign stackOp   = ~i7 & ~i6 & i5;
  assign sigEnable = ~i7 & ~i6 & ~i5 & i4 & i3;

  always_comb begin
    // NOTE: every output gets its inactive value first so no path through this block infers a latch.
    M    = 1'b0;
    S    = 1'b0;
    J    = 1'b0;
    LJ   = 1'b0;
    MW   = 1'b0;
    MC   = 1'b0;
    RD   = 1'b0;
    WR   = 1'b0;
    Y    = 1'b0;
    WA   = 1'b0;
    WC   = 1'b0;
    nCLI = 1'b1;
    nLJR = 1'b1;
    nISP = 1'b1;
    RS   = 2'b00;
    ALU  = 4'h0;
    nSIG = 8'hFF;
    if (rst_n) begin
      M    = memAccess;
      S    = i4;
      J    = i7 & i6 & i5 & cycle & ~(carry & i4);
      LJ   = longJump;
      nCLI = ~(longJump & i1);
      nLJR = ~(longJump & i2);
      MW   = memAccess & i5;
      MC   = i7 & ~cycle;
      RD   = zeroHigh & i2;
      WR   = zeroHigh & i3;
      Y    = i5;
      RS   = {i1 | i6, inst[0]};
      WA   = (memAccess & ~i5) | (wrPath & ~(i4 & ~i3 & ~i2));
      nISP = ~stackOp;
      WC   = (wrPath | stackOp) & i4;
      ALU  = i6 ? inst[3:0] : {1'b0, ~i7 & i5, 2'b00};
      if (sigEnable) nSIG = ~(8'h01 << inst[2:0]);
    end
  end

endmodule

// File: tb/tb_control.sv
// Self-checking bench for control: directed vector table, exhaustive sweep against a
// field-level reference model, random vectors, and asynchronous reset sequences.
module tb_control;

  typedef struct packed {
    logic [13:0] strobes;  // M,S,J,LJ,MW,MC,RD,WR,Y,WA,WC,nCLI,nLJR,nISP
    logic [1:0]  rs;
    logic [3:0]  alu;
    logic [7:0]  nsig;
  } outs_t;

  typedef struct {
    string      name;
    logic [7:0] inst;
    logic       cycle;
    logic       carry;
    outs_t      exp;
  } vec_t;

  logic clk = 1'b0;
  logic rst_n, cycle, ncycle, carry;
  logic [7:0] inst;
  logic M, S, J, LJ, MW, MC, RD, WR, Y, WA, WC, nCLI, nLJR, nISP;
  logic [1:0] RS;
  logic [3:0] ALU;
  logic [7:0] nSIG;

  int checks = 0;
  int errors = 0;

  control dut (
    .clk(clk), .rst_n(rst_n), .inst(inst), .cycle(cycle), .ncycle(ncycle), .carry(carry),
    .M(M), .S(S), .J(J), .LJ(LJ), .MW(MW), .MC(MC), .RD(RD), .WR(WR), .Y(Y),
    .WA(WA), .WC(WC), .nCLI(nCLI), .nLJR(nLJR), .nISP(nISP),
    .RS(RS), .ALU(ALU), .nSIG(nSIG)
  );

  always #5 clk = ~clk;

  function automatic outs_t actual();
    return '{strobes: {M, S, J, LJ, MW, MC, RD, WR, Y, WA, WC, nCLI, nLJR, nISP},
             rs: RS, alu: ALU, nsig: nSIG};
  endfunction

  function automatic outs_t mk(logic [13:0] st, logic [1:0] rs, logic [3:0] alu, logic [7:0] ns);
    return '{strobes: st, rs: rs, alu: alu, nsig: ns};
  endfunction

  function automatic outs_t resetOuts();
    return mk(14'b00000000000111, 2'b00, 4'h0, 8'hFF);
  endfunction

  // Reference model phrased as opcode-field matches rather than gate equations.
  function automatic outs_t model(logic [7:0] in, logic cyc, logic cy);
    logic m, s, j, lj, mw, mc, rd, wr, y, wa, wc, ncli, nljr, nisp, p, zero, stk;
    logic [3:0] alu;
    logic [7:0] ns;
    zero = (in[7:4] == 4'h0);
    stk  = (in[7:5] == 3'b001);
    p    = (in[7:6] == 2'b01) || (cyc && in[6:5] == 2'b10);
    m    = (in[7:6] == 2'b10) && cyc;
    s    = in[4];
    j    = (in[7:5] == 3'b111) && cyc && !(cy && in[4]);
    lj   = (in[7:3] == 5'b00010);
    ncli = !(lj && in[1]);
    nljr = !(lj && in[2]);
    mw   = m && in[5];
    mc   = in[7] && !cyc;
    rd   = zero && in[2];
    wr   = zero && in[3];
    y    = in[5];
    wa   = (m && !in[5]) || (p && in[4:2] != 3'b100);
    nisp = !stk;
    wc   = (p || stk) && in[4];
    alu  = in[6] ? in[3:0] : (stk ? 4'd4 : 4'd0);
    ns   = (in[7:3] == 5'b00011) ? ~(8'd1 << in[2:0]) : 8'hFF;
    return mk({m, s, j, lj, mw, mc, rd, wr, y, wa, wc, ncli, nljr, nisp},
              {in[1] | in[6], in[0]}, alu, ns);
  endfunction

  task automatic check(input string name, input outs_t got, input outs_t exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got strobes=%b RS=%b ALU=%h nSIG=%h, expected strobes=%b RS=%b ALU=%h nSIG=%h",
               name, got.strobes, got.rs, got.alu, got.nsig, exp.strobes, exp.rs, exp.alu, exp.nsig);
    end
  endtask

  task automatic drive(input logic [7:0] in, input logic cyc, input logic cy);
    @(negedge clk);
    inst = in; cycle = cyc; ncycle = ~cyc; carry = cy;
    #1;
  endtask

  vec_t table_v[$];

  initial begin
    rst_n = 1'b0; inst = 8'h00; cycle = 1'b0; ncycle = 1'b1; carry = 1'b0;

    table_v.push_back('{"ld_mem_c1",  8'h80, 1'b1, 1'b0, mk(14'b10000000010111, 2'b00, 4'h0, 8'hFF)});
    table_v.push_back('{"ld_mem_c0",  8'h80, 1'b0, 1'b0, mk(14'b00000100000111, 2'b00, 4'h0, 8'hFF)});
    table_v.push_back('{"jmp_carry",  8'hF0, 1'b1, 1'b1, mk(14'b01000000100111, 2'b10, 4'h0, 8'hFF)});
    table_v.push_back('{"jmp_nocy",   8'hF0, 1'b1, 1'b0, mk(14'b01100000100111, 2'b10, 4'h0, 8'hFF)});
    table_v.push_back('{"long_jump",  8'h16, 1'b0, 1'b0, mk(14'b01010000000001, 2'b10, 4'h0, 8'hFF)});
    table_v.push_back('{"signal6",    8'h1E, 1'b0, 1'b0, mk(14'b01000000000111, 2'b10, 4'h0, 8'hBF)});
    table_v.push_back('{"reg_rdwr",   8'h0C, 1'b0, 1'b0, mk(14'b00000011000111, 2'b00, 4'h0, 8'hFF)});
    table_v.push_back('{"stack_op",   8'h24, 1'b0, 1'b0, mk(14'b00000000100110, 2'b00, 4'h4, 8'hFF)});
    table_v.push_back('{"alu_op5",    8'h45, 1'b0, 1'b0, mk(14'b00000000010111, 2'b11, 4'h5, 8'hFF)});
    table_v.push_back('{"st_mem_c1",  8'hA0, 1'b1, 1'b0, mk(14'b10001000100111, 2'b00, 4'h0, 8'hFF)});

    // Reset held with an active-looking instruction, then released between clock edges.
    drive(8'hF7, 1'b1, 1'b0);
    check("reset_hold", actual(), resetOuts());
    @(negedge clk);
    #2 rst_n = 1'b1;
    #1 check("reset_release", actual(), model(8'hF7, 1'b1, 1'b0));

    foreach (table_v[k]) begin
      drive(table_v[k].inst, table_v[k].cycle, table_v[k].carry);
      check(table_v[k].name, actual(), table_v[k].exp);
    end

    // Exhaustive {inst, cycle, carry} sweep with an asynchronous reset pulse in the middle.
    for (int v = 0; v < 1024; v++) begin
      logic [9:0] code;
      code = v[9:0];
      drive(code[9:2], code[1], code[0]);
      check($sformatf("sweep_%03h", code), actual(), model(code[9:2], code[1], code[0]));
      checks++;
      if ($countones(~nSIG) > 1) begin
        errors++;
        $display("FAIL onehot_%03h: nSIG=%h has more than one low bit", code, nSIG);
      end
      if (v == 512) begin
        #1 rst_n = 1'b0;
        #1 check("midsweep_reset", actual(), resetOuts());
        inst = 8'h1B; cycle = 1'b1; ncycle = 1'b0; carry = 1'b1;
        #1 check("reset_inputs_move", actual(), resetOuts());
        rst_n = 1'b1;
        #1 check("midsweep_release", actual(), model(8'h1B, 1'b1, 1'b1));
      end
    end

    // Random vectors, including carry toggles on a fixed instruction to confirm carry only moves J.
    for (int r = 0; r < 200; r++) begin
      logic [7:0] ri;
      logic rc, rk;
      ri = 8'($urandom);
      rc = 1'($urandom);
      rk = 1'($urandom);
      drive(ri, rc, rk);
      check($sformatf("rand_%02h_%0b%0b", ri, rc, rk), actual(), model(ri, rc, rk));
      carry = ~rk;
      #1 check($sformatf("rand_cy_%02h", ri), actual(), model(ri, rc, ~rk));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
